// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Control unit for a multicycle MIPS subset (R-type add/sub/and, addi, lw, sw, beq, j).
//   Sequences the datapath one state per cycle. All outputs decode the registered state.
//   Two exceptions: alu_op in EXEC_R follows funct, and pc_write in BRANCH follows zero.
//   The illegal pulse in DECODE/EXEC_R also follows opcode/funct.
//
// Parameters
//   MEM_WAIT    extra wait cycles after each memory access (FETCH, MEM_RD), 0..7
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset
//   opcode      IR[31:26]
//   funct       IR[5:0]
//   zero        ALU zero flag
//   alu_src_a   0 = PC, 1 = register A
//   alu_src_b   00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = shifted imm
//   alu_op      001 add, 010 sub, 011 and, 000 idle
//   pc_write    PC load enable
//   pc_source   00 ALU result, 01 ALUOut, 10 jump target
//   ir_write    IR load enable
//   mem_write   memory write strobe
//   i_or_d      0 = PC address, 1 = ALUOut address
//   reg_write   register file write
//   reg_dst     0 = rt, 1 = rd
//   mem_to_reg  0 = ALUOut, 1 = MDR
//   illegal     one-cycle pulse on undecoded opcode/funct
//   state_dbg   current state encoding:
//               0 RESET, 1 FETCH, 2 FETCH_WAIT, 3 DECODE, 4 EXEC_R, 5 WB_R, 6 EXEC_I,
//               7 WB_I, 8 MEM_ADDR, 9 MEM_RD, 10 WB_MEM, 11 MEM_WR, 12 BRANCH, 13 JUMP
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        StReset     = 4'd0,
        StFetch     = 4'd1,
        StFetchWait = 4'd2,
        StDecode    = 4'd3,
        StExecR     = 4'd4,
        StWbR       = 4'd5,
        StExecI     = 4'd6,
        StWbI       = 4'd7,
        StMemAddr   = 4'd8,
        StMemRd     = 4'd9,
        StWbMem     = 4'd10,
        StMemWr     = 4'd11,
        StBranch    = 4'd12,
        StJump      = 4'd13
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;

    localparam logic [2:0] AluIdle = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluAnd  = 3'b011;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBShift = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [2:0] MaxCnt = 3'(MEM_WAIT);

    state_e     state_q;
    logic [2:0] cnt_q;
    logic       wait_done;

    // Counter has reached the configured wait length.
    assign wait_done = (cnt_q >= MaxCnt);

    // ALU operation for an R-type funct; AluIdle marks an undecoded funct.
    function automatic logic [2:0] funct_op(input logic [5:0] f);
        case (f)
            FnAdd:   funct_op = AluAdd;
            FnSub:   funct_op = AluSub;
            FnAnd:   funct_op = AluAnd;
            default: funct_op = AluIdle;
        endcase
    endfunction

    // State and wait counter. The counter defaults to clear so that any exit
    // from a wait state leaves it at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            cnt_q   <= 3'd0;
        end else begin
            cnt_q <= 3'd0;
            case (state_q)
                StReset: state_q <= StFetch;
                StFetch: begin
                    if (MEM_WAIT == 0) begin
                        state_q <= StDecode;
                    end else begin
                        // The FETCH cycle is the access itself; FETCH_WAIT then
                        // covers the MEM_WAIT extra cycles.
                        state_q <= StFetchWait;
                        cnt_q   <= 3'd1;
                    end
                end
                StFetchWait: begin
                    if (wait_done) begin
                        state_q <= StDecode;
                    end else begin
                        state_q <= StFetchWait;
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                StDecode: begin
                    case (opcode)
                        OpRtype:    state_q <= StExecR;
                        OpAddi:     state_q <= StExecI;
                        OpLw, OpSw: state_q <= StMemAddr;
                        OpBeq:      state_q <= StBranch;
                        OpJ:        state_q <= StJump;
                        default:    state_q <= StFetch;
                    endcase
                end
                StExecR:   state_q <= (funct_op(funct) == AluIdle) ? StFetch : StWbR;
                StExecI:   state_q <= StWbI;
                StMemAddr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
                StMemRd: begin
                    // Access cycle plus MEM_WAIT extra cycles, all in this state.
                    if (wait_done) begin
                        state_q <= StWbMem;
                    end else begin
                        state_q <= StMemRd;
                        cnt_q   <= cnt_q + 3'd1;
                    end
                end
                StWbR, StWbI, StWbMem, StMemWr, StBranch, StJump: state_q <= StFetch;
                default: state_q <= StReset;
            endcase
        end
    end

    // Output decode of the registered state; every output defaults to zero.
    always_comb begin
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBReg;
        alu_op     = AluIdle;
        pc_write   = 1'b0;
        pc_source  = PcAlu;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                alu_src_b = SrcBFour;
                alu_op    = AluAdd;
                if (MEM_WAIT == 0) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            StFetchWait: begin
                // Only the final wait cycle latches IR and PC+4.
                if (wait_done) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SrcBFour;
                    alu_op    = AluAdd;
                end
            end
            StDecode: begin
                alu_src_b = SrcBShift;
                alu_op    = AluAdd;
                case (opcode)
                    OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpJ: illegal = 1'b0;
                    default:                                 illegal = 1'b1;
                endcase
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = funct_op(funct);
                illegal   = (funct_op(funct) == AluIdle);
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StExecI, StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
            end
            StWbI: reg_write = 1'b1;
            StMemRd: i_or_d = 1'b1;
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = PcAluOut;
                pc_write  = zero;
            end
            StJump: begin
                pc_source = PcJump;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm. Two instances: MEM_WAIT = 1 (main)
// and MEM_WAIT = 0. Each observation packs {state, outputs} into 20 bits and is
// compared against hand-written per-state expectations.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       alu_src_a, pc_write, ir_write, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;

    logic       alu_src_a0, pc_write0, ir_write0, mem_write0, i_or_d0;
    logic       reg_write0, reg_dst0, mem_to_reg0, illegal0;
    logic [1:0] alu_src_b0, pc_source0;
    logic [2:0] alu_op0;
    logic [3:0] state_dbg0;

    int total;
    int bad;

    multicycle_ctrl_fsm #(.MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write),
        .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state_dbg(state_dbg)
    );

    multicycle_ctrl_fsm #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
        .pc_write(pc_write0), .pc_source(pc_source0), .ir_write(ir_write0),
        .mem_write(mem_write0), .i_or_d(i_or_d0), .reg_write(reg_write0),
        .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .illegal(illegal0),
        .state_dbg(state_dbg0)
    );

    // {state, a, b, op, pcw, pcs, irw, mw, iod, rw, rd, m2r, ill}
    logic [19:0] obs, obs0;
    assign obs  = {state_dbg, alu_src_a, alu_src_b, alu_op, pc_write, pc_source, ir_write,
                   mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, illegal};
    assign obs0 = {state_dbg0, alu_src_a0, alu_src_b0, alu_op0, pc_write0, pc_source0,
                   ir_write0, mem_write0, i_or_d0, reg_write0, reg_dst0, mem_to_reg0, illegal0};

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_BAD = 6'h3F;

    //                                st     a     b      op     pcw   pcs    irw   mw    iod   rw    rd    m2r   ill
    localparam logic [19:0] E_RESET   = {4'd0, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH   = {4'd1, 1'b0, 2'b01, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_FETCH0  = {4'd1, 1'b0, 2'b01, 3'b001, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_FWAIT   = {4'd2, 1'b0, 2'b01, 3'b001, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_DECODE  = {4'd3, 1'b0, 2'b11, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_DEC_ILL = {4'd3, 1'b0, 2'b11, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [19:0] E_EXR_ADD = {4'd4, 1'b1, 2'b00, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_EXR_SUB = {4'd4, 1'b1, 2'b00, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_EXR_AND = {4'd4, 1'b1, 2'b00, 3'b011, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_EXR_ILL = {4'd4, 1'b1, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [19:0] E_WB_R    = {4'd5, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] E_EXEC_I  = {4'd6, 1'b1, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_WB_I    = {4'd7, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_MADDR   = {4'd8, 1'b1, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_MEM_RD  = {4'd9, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_WB_MEM  = {4'd10, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [19:0] E_MEM_WR  = {4'd11, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_BR_T    = {4'd12, 1'b1, 2'b00, 3'b010, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_BR_N    = {4'd12, 1'b1, 2'b00, 3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [19:0] E_JUMP    = {4'd13, 1'b0, 2'b00, 3'b000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held 3 cycles, released into a jump instruction.
    task automatic test_reset();
        logic [19:0] exp_s [8];
        exp_s = '{E_RESET, E_RESET, E_RESET, E_FETCH, E_FWAIT, E_DECODE, E_JUMP, E_FETCH};
        reset = 1'b1;
        opcode = OP_J;
        funct = 6'h00;
        zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL reset_seq[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
            if (i == 2) reset = 1'b0;
        end
    endtask

    // Starts and ends observed in FETCH.
    task automatic test_rtype(input logic [5:0] fn, input logic [19:0] e_exec);
        logic [19:0] exp_s [6];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, e_exec, E_WB_R, E_FETCH};
        opcode = OP_R;
        funct = fn;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL rtype_%h[%0d]: got %h want %h", fn, i, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [19:0] exp_s [6];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_EXEC_I, E_WB_I, E_FETCH};
        opcode = OP_ADDI;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL addi[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [19:0] exp_s [8];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_MADDR, E_MEM_RD, E_MEM_RD, E_WB_MEM, E_FETCH};
        opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL lw[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [19:0] exp_s [6];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_MADDR, E_MEM_WR, E_FETCH};
        opcode = OP_SW;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL sw[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_beq(input logic z);
        logic [19:0] exp_s [5];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, (z ? E_BR_T : E_BR_N), E_FETCH};
        opcode = OP_BEQ;
        zero = z;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL beq_z%0d[%0d]: got %h want %h", z, i, obs, exp_s[i]);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal_op();
        logic [19:0] exp_s [4];
        exp_s = '{E_FETCH, E_FWAIT, E_DEC_ILL, E_FETCH};
        opcode = OP_BAD;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL illegal_op[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
        end
    endtask

    task automatic test_illegal_funct();
        logic [19:0] exp_s [5];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_EXR_ILL, E_FETCH};
        opcode = OP_R;
        funct = 6'h25;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL illegal_funct[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
        end
    endtask

    // Reset raised during MEM_WR, dropped one cycle later.
    task automatic test_abort_mem_wr();
        logic [19:0] exp_s [7];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_MADDR, E_MEM_WR, E_RESET, E_FETCH};
        opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL abort_mem_wr[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
            if (i == 4) reset = 1'b1;
            if (i == 5) reset = 1'b0;
        end
    endtask

    // Reset raised during WB_R, dropped one cycle later.
    task automatic test_abort_wb_r();
        logic [19:0] exp_s [7];
        exp_s = '{E_FETCH, E_FWAIT, E_DECODE, E_EXR_ADD, E_WB_R, E_RESET, E_FETCH};
        opcode = OP_R;
        funct = 6'h20;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) step();
            total++;
            if (obs !== exp_s[i]) begin
                bad++;
                $display("FAIL abort_wb_r[%0d]: got %h want %h", i, obs, exp_s[i]);
            end
            if (i == 4) reset = 1'b1;
            if (i == 5) reset = 1'b0;
        end
    endtask

    // MEM_WAIT = 0 instance: FETCH goes straight to DECODE with IR/PC writes in FETCH.
    task automatic test_memwait0();
        logic [19:0] exp_s [5];
        exp_s = '{E_RESET, E_FETCH0, E_DECODE, E_JUMP, E_FETCH0};
        reset = 1'b1;
        opcode = OP_J;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (obs0 !== exp_s[i]) begin
                bad++;
                $display("FAIL memwait0[%0d]: got %h want %h", i, obs0, exp_s[i]);
            end
            if (i == 0) reset = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        test_reset();
        test_rtype(6'h20, E_EXR_ADD);
        test_rtype(6'h22, E_EXR_SUB);
        test_rtype(6'h24, E_EXR_AND);
        test_addi();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal_op();
        test_illegal_funct();
        test_abort_mem_wr();
        test_abort_wb_r();
        test_memwait0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
